// File: rtl/segasys1_pkg.sv
// Shared timing constants for the SEGA System 1/2 video path, plus a small
// window-compare helper used by the sync generator.
package segasys1_pkg;

    localparam int H_TOTAL  = 384;
    localparam int H_VIS    = 256;
    localparam int HS_START = 300;
    localparam int HS_LEN   = 32;
    localparam int V_TOTAL  = 264;
    localparam int V_VIS    = 224;
    localparam int VS_START = 240;
    localparam int VS_LEN   = 3;

    // True when pos lies in [start, start+len-1]. The work is done in 11-bit
    // signed so a start pulled below zero by a negative offset still compares
    // correctly against the unsigned counter.
    function automatic logic in_window(input logic [8:0] pos,
                                       input logic signed [9:0] start,
                                       input logic [9:0] len);
        logic signed [10:0] p;
        logic signed [10:0] s;
        logic signed [10:0] e;
        p = $signed({2'b00, pos});
        s = {start[9], start};
        e = s + $signed({1'b0, len});
        return (p >= s) && (p < e);
    endfunction

endpackage

// File: rtl/segasys1_hvgen.sv
// Horizontal/vertical raster counters with registered blanking, sync and a
// frame-start strobe. Sync position is trimmed by signed offsets that are
// only taken on board at the frame boundary so a frame is never torn.
module segasys1_hvgen #(
    parameter int H_TOTAL  = segasys1_pkg::H_TOTAL,
    parameter int H_VIS    = segasys1_pkg::H_VIS,
    parameter int HS_START = segasys1_pkg::HS_START,
    parameter int HS_LEN   = segasys1_pkg::HS_LEN,
    parameter int V_TOTAL  = segasys1_pkg::V_TOTAL,
    parameter int V_VIS    = segasys1_pkg::V_VIS,
    parameter int VS_START = segasys1_pkg::VS_START,
    parameter int VS_LEN   = segasys1_pkg::VS_LEN
) (
    input  logic       clk48M,
    input  logic       reset,
    input  logic       PCLK_EN,
    input  logic [3:0] HOFS,
    input  logic [2:0] VOFS,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       FRAME_ST
);

    import segasys1_pkg::in_window;

    logic [3:0]        hofs_q;
    logic [2:0]        vofs_q;
    logic [3:0]        hofs_nxt;
    logic [2:0]        vofs_nxt;
    logic              h_wrap;
    logic              v_wrap;
    logic              frame_wrap;
    logic [8:0]        ph_nxt;
    logic [8:0]        pv_nxt;
    logic signed [9:0] hs0;
    logic signed [9:0] vs0;

    // Next counter values, offsets and sync starts for the coming step; flags
    // are computed from these so they line up with the new PH/PV.
    always_comb begin
        h_wrap     = (PH == 9'(H_TOTAL - 1));
        v_wrap     = (PV == 9'(V_TOTAL - 1));
        frame_wrap = h_wrap && v_wrap;
        ph_nxt     = h_wrap ? 9'd0 : PH + 9'd1;
        pv_nxt     = PV;
        if (h_wrap)
            pv_nxt = v_wrap ? 9'd0 : PV + 9'd1;
        hofs_nxt   = frame_wrap ? HOFS : hofs_q;
        vofs_nxt   = frame_wrap ? VOFS : vofs_q;
        hs0        = 10'(HS_START) + {{6{hofs_nxt[3]}}, hofs_nxt};
        vs0        = 10'(VS_START) + {{7{vofs_nxt[2]}}, vofs_nxt};
    end

    // Counters, offset latches and flags advance on pixel enables; the frame
    // strobe is evaluated every clock so it lasts exactly one clk48M cycle.
    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            PH       <= 9'd0;
            PV       <= 9'd0;
            HBLANK   <= 1'b0;
            VBLANK   <= 1'b0;
            HSYNC    <= 1'b0;
            VSYNC    <= 1'b0;
            FRAME_ST <= 1'b0;
            hofs_q   <= 4'd0;
            vofs_q   <= 3'd0;
        end else begin
            FRAME_ST <= PCLK_EN && frame_wrap;
            if (PCLK_EN) begin
                PH     <= ph_nxt;
                PV     <= pv_nxt;
                hofs_q <= hofs_nxt;
                vofs_q <= vofs_nxt;
                HBLANK <= (ph_nxt >= 9'(H_VIS));
                VBLANK <= (pv_nxt >= 9'(V_VIS));
                HSYNC  <= in_window(ph_nxt, hs0, 10'(HS_LEN));
                VSYNC  <= in_window(pv_nxt, vs0, 10'(VS_LEN));
            end
        end
    end

endmodule

// File: tb/tb_segasys1_hvgen.sv
// Bench for segasys1_hvgen. Instance a runs the default raster with a pixel
// enable every 8th clock; instance b runs a shrunken raster (64x40) with the
// enable held high so whole frames, offset latching and mid-frame reset fit
// in a short run.
module tb_segasys1_hvgen;
    import segasys1_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       rst_a, en_a, rst_b, en_b;
    logic [3:0] hofs_a, hofs_b;
    logic [2:0] vofs_a, vofs_b;
    logic [8:0] ph_a, pv_a, ph_b, pv_b;
    logic       hb_a, vb_a, hs_a, vs_a, fs_a;
    logic       hb_b, vb_b, hs_b, vs_b, fs_b;

    segasys1_hvgen dut_a (
        .clk48M(clk), .reset(rst_a), .PCLK_EN(en_a), .HOFS(hofs_a), .VOFS(vofs_a),
        .PH(ph_a), .PV(pv_a), .HBLANK(hb_a), .VBLANK(vb_a), .HSYNC(hs_a),
        .VSYNC(vs_a), .FRAME_ST(fs_a)
    );

    segasys1_hvgen #(
        .H_TOTAL(64), .H_VIS(40), .HS_START(48), .HS_LEN(4),
        .V_TOTAL(40), .V_VIS(30), .VS_START(33), .VS_LEN(2)
    ) dut_b (
        .clk48M(clk), .reset(rst_b), .PCLK_EN(en_b), .HOFS(hofs_b), .VOFS(vofs_b),
        .PH(ph_b), .PV(pv_b), .HBLANK(hb_b), .VBLANK(vb_b), .HSYNC(hs_b),
        .VSYNC(vs_b), .FRAME_ST(fs_b)
    );

    typedef struct {
        int step;
        int ph;
        int pv;
        int hb;
        int hs;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One pixel step on instance a: enable for one clock, then seven idle.
    task automatic step_a();
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic chk_all_zero_a(input string tag);
        chk({tag, "_ph"}, int'(ph_a), 0);
        chk({tag, "_pv"}, int'(pv_a), 0);
        chk({tag, "_hb"}, int'(hb_a), 0);
        chk({tag, "_vb"}, int'(vb_a), 0);
        chk({tag, "_hs"}, int'(hs_a), 0);
        chk({tag, "_vs"}, int'(vs_a), 0);
        chk({tag, "_fs"}, int'(fs_a), 0);
    endtask

    task automatic chk_all_zero_b(input string tag);
        chk({tag, "_ph"}, int'(ph_b), 0);
        chk({tag, "_pv"}, int'(pv_b), 0);
        chk({tag, "_hb"}, int'(hb_b), 0);
        chk({tag, "_vb"}, int'(vb_b), 0);
        chk({tag, "_hs"}, int'(hs_b), 0);
        chk({tag, "_vs"}, int'(vs_b), 0);
        chk({tag, "_fs"}, int'(fs_b), 0);
    endtask

    // Run instance b until the next FRAME_ST (bounded), summarising where the
    // flags were high, and optionally change the offsets at PV=15 mid-frame.
    task automatic frame_b(input string tag, input int chg, input logic [3:0] h,
                           input logic [2:0] v, input int e_n, input int e_hlo,
                           input int e_hhi, input int e_vlo, input int e_vhi);
        int n = 0;
        int hs_lo = 999, hs_hi = -1, hs_n = 0;
        int vs_lo = 999, vs_hi = -1, vs_n = 0;
        int vb_lo = 999, vb_hi = -1, vb_n = 0;
        int hb_n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (chg != 0 && ph_b == 9'd0 && pv_b == 9'd15) begin
                hofs_b = h;
                vofs_b = v;
            end
            if (hs_b) begin
                hs_n++;
                if (int'(ph_b) < hs_lo) hs_lo = int'(ph_b);
                if (int'(ph_b) > hs_hi) hs_hi = int'(ph_b);
            end
            if (vs_b) begin
                vs_n++;
                if (int'(pv_b) < vs_lo) vs_lo = int'(pv_b);
                if (int'(pv_b) > vs_hi) vs_hi = int'(pv_b);
            end
            if (vb_b) begin
                vb_n++;
                if (int'(pv_b) < vb_lo) vb_lo = int'(pv_b);
                if (int'(pv_b) > vb_hi) vb_hi = int'(pv_b);
            end
            if (hb_b) hb_n++;
            if (fs_b) break;
        end
        chk({tag, "_period"}, n, e_n);
        chk({tag, "_hs_lo"}, hs_lo, e_hlo);
        chk({tag, "_hs_hi"}, hs_hi, e_hhi);
        chk({tag, "_hs_cnt"}, hs_n, 160);
        chk({tag, "_vs_lo"}, vs_lo, e_vlo);
        chk({tag, "_vs_hi"}, vs_hi, e_vhi);
        chk({tag, "_vs_cnt"}, vs_n, 128);
        chk({tag, "_vb_lo"}, vb_lo, 30);
        chk({tag, "_vb_hi"}, vb_hi, 39);
        chk({tag, "_vb_cnt"}, vb_n, 640);
        chk({tag, "_hb_cnt"}, hb_n, 960);
        chk({tag, "_end_ph"}, int'(ph_b), 0);
        chk({tag, "_end_pv"}, int'(pv_b), 0);
        chk({tag, "_end_vb"}, int'(vb_b), 0);
    endtask

    initial begin
        int done;
        int changed;
        int fs_seen;
        int found;

        vecs[0]  = '{1,   1,   0, 0, 0};
        vecs[1]  = '{2,   2,   0, 0, 0};
        vecs[2]  = '{255, 255, 0, 0, 0};
        vecs[3]  = '{256, 256, 0, 1, 0};
        vecs[4]  = '{299, 299, 0, 1, 0};
        vecs[5]  = '{300, 300, 0, 1, 1};
        vecs[6]  = '{331, 331, 0, 1, 1};
        vecs[7]  = '{332, 332, 0, 1, 0};
        vecs[8]  = '{383, 383, 0, 1, 0};
        vecs[9]  = '{384, 0,   1, 0, 0};
        vecs[10] = '{385, 1,   1, 0, 0};

        rst_a = 1'b1; en_a = 1'b0; hofs_a = 4'd0; vofs_a = 3'd0;
        rst_b = 1'b1; en_b = 1'b0; hofs_b = 4'd0; vofs_b = 3'd0;

        // ---- instance a: reset state, then the first line at 1/8 rate ----
        repeat (3) @(negedge clk);
        chk_all_zero_a("a_in_reset");
        rst_a = 1'b0;
        @(negedge clk);
        chk_all_zero_a("a_released");

        done = 0;
        for (int i = 0; i < 11; i++) begin
            while (done < vecs[i].step) begin
                step_a();
                done++;
            end
            chk($sformatf("a_ph[%0d]", i), int'(ph_a), vecs[i].ph);
            chk($sformatf("a_pv[%0d]", i), int'(pv_a), vecs[i].pv);
            chk($sformatf("a_hb[%0d]", i), int'(hb_a), vecs[i].hb);
            chk($sformatf("a_hs[%0d]", i), int'(hs_a), vecs[i].hs);
            chk($sformatf("a_vb[%0d]", i), int'(vb_a), 0);
            chk($sformatf("a_vs[%0d]", i), int'(vs_a), 0);
            chk($sformatf("a_fs[%0d]", i), int'(fs_a), 0);
        end

        // ---- instance a: enable held low, everything must freeze ----
        changed = 0;
        fs_seen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ph_a != 9'd1 || pv_a != 9'd1 || hb_a || vb_a || hs_a || vs_a) changed++;
            if (fs_a) fs_seen++;
        end
        chk("a_hold_changes", changed, 0);
        chk("a_hold_fs", fs_seen, 0);

        // ---- instance b: whole frames with enable held high ----
        @(negedge clk);
        chk_all_zero_b("b_in_reset");
        rst_b = 1'b0;
        en_b  = 1'b1;
        frame_b("b_f0", 0, 4'd0, 3'd0, 2560, 48, 51, 33, 34);
        // HOFS=-8, VOFS=+3 applied mid-frame: no effect until next frame
        frame_b("b_f1", 1, 4'b1000, 3'b011, 2560, 48, 51, 33, 34);
        frame_b("b_f2", 0, 4'd0, 3'd0, 2560, 40, 43, 36, 37);
        // HOFS=+7, VOFS=-4 applied mid-frame
        frame_b("b_f3", 1, 4'b0111, 3'b100, 2560, 40, 43, 36, 37);
        frame_b("b_f4", 0, 4'd0, 3'd0, 2560, 55, 58, 29, 30);

        // ---- instance b: asynchronous reset with every flag high ----
        found = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (ph_b == 9'd56 && pv_b == 9'd30) begin
                found = 1;
                break;
            end
        end
        chk("b_rst_point_found", found, 1);
        chk("b_pre_rst_hb", int'(hb_b), 1);
        chk("b_pre_rst_vb", int'(vb_b), 1);
        chk("b_pre_rst_hs", int'(hs_b), 1);
        chk("b_pre_rst_vs", int'(vs_b), 1);
        rst_b = 1'b1;
        #1;
        chk_all_zero_b("b_async_rst");
        @(negedge clk);
        chk_all_zero_b("b_rst_held");
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_first_step_ph", int'(ph_b), 1);
        chk("b_first_step_pv", int'(pv_b), 0);
        chk("b_first_step_fs", int'(fs_b), 0);
        // Offsets were cleared by reset even though HOFS/VOFS still read +7/-4
        frame_b("b_f5", 0, 4'd0, 3'd0, 2559, 48, 51, 33, 34);
        frame_b("b_f6", 0, 4'd0, 3'd0, 2560, 55, 58, 29, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/segasys1_hvgen.md
# segasys1_hvgen

Video timing generator for the SEGA System 1/2 core: it drives the `PH`/`PV` pixel coordinates that the system top and its video block consume. It also generates blanking, sync and a frame-start strobe for the MiSTer video output path. It advances on the pixel clock enable produced by the video block. The 256×224 active raster can be shifted in position by latching small signed sync offsets at frame boundaries.

## Interface
Parameters:
- `H_TOTAL`, 384, pixel clocks per line
- `H_VIS`, 256, active pixels per line
- `HS_START`, 300, nominal HSYNC assert column
- `HS_LEN`, 32, HSYNC width in pixels
- `V_TOTAL`, 264, lines per frame
- `V_VIS`, 224, active lines
- `VS_START`, 240, nominal VSYNC assert line
- `VS_LEN`, 3, VSYNC width in lines

Ports:
- `clk48M`  in  1  system clock. One clock; reset is asynchronous and active-high.
- `reset`  in  1  asynchronous, active-high
- `PCLK_EN`  in  1  pixel enable, one clk48M cycle in every 8
- `HOFS`  in  4  signed horizontal sync offset, −8..+7 pixels
- `VOFS`  in  3  signed vertical sync offset, −4..+3 lines
- `PH`  out  9  horizontal counter, 0..H_TOTAL−1
- `PV`  out  9  vertical counter, 0..V_TOTAL−1
- `HBLANK`  out  1  high while PH ≥ H_VIS
- `VBLANK`  out  1  high while PV ≥ V_VIS
- `HSYNC`  out  1  active-high horizontal sync
- `VSYNC`  out  1  active-high vertical sync
- `FRAME_ST`  out  1  one-cycle strobe at frame start

## Operation
- Counters advance only on clk48M edges where PCLK_EN=1. Outputs hold otherwise.
- Horizontal counting:
  - PH increments by 1 per step.
  - When PH = H_TOTAL−1, the next step sets PH to 0 and advances PV.
- Vertical counting: when PV = V_TOTAL−1 and PH wraps, PV goes to 0 (frame boundary).
- Offset latching:
  - HOFS and VOFS are sampled into internal registers `hofs_q` and `vofs_q` only at the frame boundary step.
  - Changing HOFS or VOFS mid-frame has no effect until the next frame.
- Sync window computation:
  - The effective HSYNC start is `hs0 = HS_START + sext(hofs_q)`, computed in 10-bit signed arithmetic. The result is always in range for the default parameters, so there is no modulo.
  - HSYNC is high for PH in [hs0, hs0+HS_LEN−1].
  - The effective VSYNC start is `vs0 = VS_START + sext(vofs_q)`.
  - VSYNC is high for PV in [vs0, vs0+VS_LEN−1]. VSYNC switches on the same step PV changes, which is the line-start step.
- HBLANK, VBLANK, HSYNC and VSYNC are registered. Each is updated on the same step as PH/PV and reflects the new counter values.
- FRAME_ST is high for exactly the one clk48M cycle that follows the step at which (PH,PV) became (0,0).
- Reset values: PH=0, PV=0, HBLANK=0, VBLANK=0, HSYNC=0, VSYNC=0, FRAME_ST=0, hofs_q=0, vofs_q=0.
- Reset mid-frame takes effect immediately and asynchronously. After release, counting resumes from (0,0) on the first PCLK_EN. No FRAME_ST is emitted for the reset-induced (0,0).

## Timing
- Latency: zero steps. All outputs are consistent with PH/PV in every cycle.
- The line period is H_TOTAL×8 = 3072 clk48M cycles, giving 15.625 kHz.
- The frame period is 264 lines, about 59.19 Hz.
- If PCLK_EN is held high continuously, the counters step every cycle. This mode is allowed and is used for fast simulation.
- HSYNC wrap is not supported: hs0+HS_LEN must be less than H_TOTAL. The same holds vertically. The defaults satisfy both constraints with every offset value.

## Structure
- The shared package `segasys1_pkg` holds the default timing constants (H_TOTAL, H_VIS, HS_START, HS_LEN, V_TOTAL, V_VIS, VS_START, VS_LEN). Video, top and the testbench import it.
- No sub-module is needed. The two counters and the compare logic stay flat in `segasys1_hvgen`.

## Test plan
- Reset release with PCLK_EN every 8th cycle:
  - PH steps 0,1,2… once per 8 cycles.
  - After 256 steps, HBLANK rises at PH=256.
  - PH wraps 383→0 and PV becomes 1.
- Full frame with PCLK_EN=1 continuously:
  - VBLANK rises at PV=224 and falls at PV=0.
  - FRAME_ST pulses once per 101376 cycles.
- HOFS=0, VOFS=0: HSYNC is high for PH 300..331 and VSYNC is high for PV 240..242.
- Offset latching:
  - Apply HOFS=−8 (4'b1000) at PV=100.
  - HSYNC stays at 300..331 for the rest of the frame.
  - From the next frame, HSYNC is 292..323.
  - With VOFS=+3, VSYNC is 243..245 from the next frame.
- Reset asserted at PH=150, PV=180:
  - All outputs are 0 within the same cycle, asynchronously.
  - After release, the first step gives PH=1, PV=0.
  - No FRAME_ST occurs until the next natural wrap.
- PCLK_EN held low for 1000 cycles: PH, PV and all flags remain constant, and FRAME_ST stays 0.
